audio_frame_buffer: RTL and testbench
=====================================

Name: audio_frame_buffer

Overview:
- Sits directly downstream of the codec left-channel Avalon-ST source, in the same position as the pass-through piper.
- Collects mono 16-bit samples into fixed-length frames using a two-bank ping-pong buffer.
- Streams each completed frame as an Avalon-ST packet, with start/end-of-packet markers, to the pitch-analysis stage.
- The codec cannot be stalled: when no bank is free, whole frames are dropped and counted.

Parameters:
- DATA_W, 16, sample width in bits.
- FRAME_LEN, 512, samples per frame; must be a power of two and at least 4.
- ADDR_W, 9, log2(FRAME_LEN); index width within a bank.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- in_data  in  DATA_W  sample from the codec left-channel source.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sink ready to accept a sample.
- out_data  out  DATA_W  frame sample to the downstream stage.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_startofpacket  out  1  marks sample index 0 of a frame.
- out_endofpacket  out  1  marks sample index FRAME_LEN-1 of a frame.
- overrun  out  1  sticky; set when any frame has been dropped.
- dropped_frames  out  16  count of dropped frames; saturates at 0xFFFF.

Behaviour:
- Reset values, applied asynchronously while reset=0:
  - in_ready=1, out_valid=0, out_startofpacket=0, out_endofpacket=0, out_data=0, overrun=0, dropped_frames=0.
  - Both banks empty; write index and read index = 0; write bank = 0; read bank = 0.
  - Any partial frame is discarded.
- Input accept:
  - A sample is accepted on a cycle with in_valid=1 and in_ready=1.
  - in_ready stays 1 in every state after reset; the block never backpressures the codec.
- Writer FSM, states WR_FILL and WR_DROP:
  - WR_FILL: each accepted sample is written to bank[wb][widx], then widx increments.
  - When the sample with widx=FRAME_LEN-1 is accepted:
    - bank wb is marked full and widx wraps to 0.
    - If bank ~wb is free, or is released in this same cycle, then wb <= ~wb and the FSM stays in WR_FILL.
    - Otherwise go to WR_DROP.
  - WR_DROP: accepted samples are discarded while widx counts through FRAME_LEN samples, so drops stay frame-aligned.
    - When widx wraps: dropped_frames increments (saturating) and overrun <= 1.
    - If bank ~wb is now free (including a same-cycle release): wb <= ~wb and go to WR_FILL. Otherwise remain in WR_DROP.
- Reader FSM, states RD_IDLE, RD_PREFETCH, RD_STREAM:
  - Full banks are read in completion order, alternating 0,1,0,1.
  - RD_IDLE: when bank rb is full, go to RD_PREFETCH. This issues a read of index 0; the bank RAM has 1-cycle read latency.
  - RD_PREFETCH: load the output register, assert out_valid, go to RD_STREAM.
  - Latency: out_valid must rise no later than 2 cycles after the cycle in which the frame's last sample is accepted.
  - RD_STREAM:
    - out_data, out_startofpacket and out_endofpacket are held stable while out_valid=1 and out_ready=0.
    - On each transfer (out_valid=1 and out_ready=1), the next sample is presented the following cycle. Full throughput is one sample per cycle while out_ready=1; a prefetch or skid register is allowed.
    - out_startofpacket=1 only with index 0; out_endofpacket=1 only with index FRAME_LEN-1.
  - On transfer of the EOP sample:
    - bank rb is released in that same cycle and rb <= ~rb.
    - If bank ~rb is already full, the next frame's prefetch starts immediately. out_valid may drop for at most 1 cycle between frames.
    - Otherwise go to RD_IDLE with out_valid=0.
- Simultaneous events:
  - The writer may complete bank X in the same cycle the reader releases bank ~X. This is not an overrun: the writer proceeds into ~X.
  - The writer never writes the bank currently being read.
- Reset mid-operation: all state returns to the reset values; no partial packet is completed afterward.
- Widths: widx and ridx are ADDR_W bits and wrap naturally. dropped_frames saturates and does not wrap.

Test Plan (FRAME_LEN=8, ADDR_W=3):
1. Assert reset=0 for 3 cycles, then release -> in_ready=1, out_valid=0, overrun=0, dropped_frames=0 throughout.
2. Feed 0x0001..0x0008 on consecutive cycles with out_ready=1 -> out_data 0x0001..0x0008 in order. SOP appears only with 0x0001 and EOP only with 0x0008. out_valid rises within 2 cycles of accepting 0x0008.
3. Feed 0x0011..0x0018 with out_ready toggling 1,0,1,0 -> each sample appears exactly once, and data/SOP/EOP are stable during out_ready=0 cycles.
4. Hold out_ready=0 and feed 24 samples 0x0001..0x0018 -> dropped_frames=1 and overrun=1 after the 24th sample. Then set out_ready=1 -> output is exactly 0x0001..0x0010 as two packets; 0x0011..0x0018 never appear.
5. With frame A streaming, time frame B's 8th sample to be accepted in the same cycle as A's EOP transfer -> dropped_frames stays 0. Frame B's packet follows with at most one idle cycle, and a third frame is accepted into A's bank.
6. Feed 0x00A1..0x00A5, pulse reset=0 for 1 cycle, then feed 0x0100..0x0107 -> output is only 0x0100..0x0107 with correct SOP/EOP; no 0x00Ax sample ever appears.

Source files
------------

// File: rtl/audio_frame_buffer.sv
// Two-bank ping-pong frame buffer: collects mono samples into FRAME_LEN frames and
// replays each completed frame as an Avalon-ST packet; frames are dropped, not stalled.
module audio_frame_buffer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 512,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic              overrun,
    output logic [15:0]       dropped_frames
);

    typedef enum logic {WR_FILL, WR_DROP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_PREFETCH, RD_STREAM} rd_state_t;

    logic [DATA_W-1:0] mem [2*FRAME_LEN];
    logic [DATA_W-1:0] ram_q;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W:0]   rd_addr;

    wr_state_t         wr_state_reg, wr_state_next;
    logic              wb_reg, wb_next;
    logic [ADDR_W-1:0] widx_reg, widx_next;
    logic [15:0]       dropped_reg, dropped_next;
    logic              overrun_reg, overrun_next;

    rd_state_t         rd_state_reg, rd_state_next;
    logic              rb_reg, rb_next;
    logic [ADDR_W-1:0] ridx_reg, ridx_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              out_valid_reg, out_valid_next;
    logic              sop_reg, sop_next;
    logic              eop_reg, eop_next;

    logic              full_reg [2];
    logic [1:0]        set_full;
    logic [1:0]        clr_full;

    logic              accept;
    logic              frame_done;
    logic              xfer;
    logic              release_now;
    logic              other_free;
    logic              next_bank_ready;

    assign in_ready    = 1'b1;
    assign accept      = in_valid;
    assign frame_done  = accept && (widx_reg == ADDR_W'(FRAME_LEN - 1));
    assign xfer        = out_valid_reg && out_ready;
    assign release_now = (rd_state_reg == RD_STREAM) && xfer && eop_reg;
    // A bank handed back by the reader this very cycle counts as free for the writer.
    assign other_free  = !full_reg[~wb_reg] || (release_now && (rb_reg == ~wb_reg));
    assign next_bank_ready = full_reg[~rb_reg] || set_full[~rb_reg];

    // Bank storage: write port for the writer, registered read port for the reader.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wb_reg, widx_reg}] <= in_data;
        if (rd_en)
            ram_q <= mem[rd_addr];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank_full
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                full_reg[gi] <= 1'b0;
            else if (set_full[gi])
                full_reg[gi] <= 1'b1;
            else if (clr_full[gi])
                full_reg[gi] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state_reg  <= WR_FILL;
            wb_reg        <= 1'b0;
            widx_reg      <= '0;
            dropped_reg   <= '0;
            overrun_reg   <= 1'b0;
            rd_state_reg  <= RD_IDLE;
            rb_reg        <= 1'b0;
            ridx_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            sop_reg       <= 1'b0;
            eop_reg       <= 1'b0;
        end else begin
            wr_state_reg  <= wr_state_next;
            wb_reg        <= wb_next;
            widx_reg      <= widx_next;
            dropped_reg   <= dropped_next;
            overrun_reg   <= overrun_next;
            rd_state_reg  <= rd_state_next;
            rb_reg        <= rb_next;
            ridx_reg      <= ridx_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            sop_reg       <= sop_next;
            eop_reg       <= eop_next;
        end
    end

    // Writer: fill the current bank, or count a whole frame away while no bank is free.
    always_comb begin
        wr_state_next = wr_state_reg;
        wb_next       = wb_reg;
        widx_next     = widx_reg;
        dropped_next  = dropped_reg;
        overrun_next  = overrun_reg;
        wr_en         = 1'b0;
        set_full      = 2'b00;
        if (accept) begin
            widx_next = widx_reg + ADDR_W'(1);
            case (wr_state_reg)
                WR_FILL: begin
                    wr_en = 1'b1;
                    if (frame_done) begin
                        set_full = wb_reg ? 2'b10 : 2'b01;
                        if (other_free)
                            wb_next = ~wb_reg;
                        else
                            wr_state_next = WR_DROP;
                    end
                end
                WR_DROP: begin
                    if (frame_done) begin
                        dropped_next = (dropped_reg == 16'hFFFF) ? dropped_reg : dropped_reg + 16'd1;
                        overrun_next = 1'b1;
                        if (other_free) begin
                            wb_next       = ~wb_reg;
                            wr_state_next = WR_FILL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Reader: ram_q always holds the sample after the one in the output register,
    // and is only refreshed on a transfer so a stall holds both stages.
    always_comb begin
        rd_state_next  = rd_state_reg;
        rb_next        = rb_reg;
        ridx_next      = ridx_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        sop_next       = sop_reg;
        eop_next       = eop_reg;
        rd_en          = 1'b0;
        rd_addr        = {rb_reg, ridx_reg};
        clr_full       = 2'b00;
        case (rd_state_reg)
            RD_IDLE: begin
                if (full_reg[rb_reg]) begin
                    rd_en         = 1'b1;
                    rd_addr       = {rb_reg, {ADDR_W{1'b0}}};
                    rd_state_next = RD_PREFETCH;
                end
            end
            RD_PREFETCH: begin
                out_data_next  = ram_q;
                out_valid_next = 1'b1;
                sop_next       = 1'b1;
                eop_next       = 1'b0;
                ridx_next      = '0;
                rd_en          = 1'b1;
                rd_addr        = {rb_reg, ADDR_W'(1)};
                rd_state_next  = RD_STREAM;
            end
            RD_STREAM: begin
                if (xfer) begin
                    if (eop_reg) begin
                        clr_full       = rb_reg ? 2'b10 : 2'b01;
                        rb_next        = ~rb_reg;
                        out_valid_next = 1'b0;
                        sop_next       = 1'b0;
                        eop_next       = 1'b0;
                        if (next_bank_ready) begin
                            rd_en         = 1'b1;
                            rd_addr       = {~rb_reg, {ADDR_W{1'b0}}};
                            rd_state_next = RD_PREFETCH;
                        end else begin
                            rd_state_next = RD_IDLE;
                        end
                    end else begin
                        out_data_next = ram_q;
                        ridx_next     = ridx_reg + ADDR_W'(1);
                        sop_next      = 1'b0;
                        eop_next      = ((ridx_reg + ADDR_W'(1)) == ADDR_W'(FRAME_LEN - 1));
                        rd_en         = 1'b1;
                        rd_addr       = {rb_reg, ridx_reg + ADDR_W'(2)};
                    end
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    assign out_data          = out_data_reg;
    assign out_valid         = out_valid_reg;
    assign out_startofpacket = sop_reg;
    assign out_endofpacket   = eop_reg;
    assign overrun           = overrun_reg;
    assign dropped_frames    = dropped_reg;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Scoreboard bench for audio_frame_buffer with 8-sample frames: stimulus pushes expected
// beats, a negedge monitor pops and compares every output transfer.
module tb_audio_frame_buffer;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 8;
    localparam int ADDR_W    = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_startofpacket;
    logic              out_endofpacket;
    logic              overrun;
    logic [15:0]       dropped_frames;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    audio_frame_buffer #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket(out_endofpacket),
        .overrun(overrun),
        .dropped_frames(dropped_frames)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] base);
        for (int i = 0; i < FRAME_LEN; i++)
            send(base + 16'(i));
    endtask

    task automatic push_frame(input logic [15:0] base);
        beat_t b;
        for (int i = 0; i < FRAME_LEN; i++) begin
            b.sop  = (i == 0);
            b.eop  = (i == FRAME_LEN - 1);
            b.data = base + 16'(i);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: one line per transfer, plus hold checks on every stalled cycle.
    initial begin
        beat_t cur;
        beat_t prev;
        beat_t exp;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cur = {out_startofpacket, out_endofpacket, out_data};
            if (!reset) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_beat", 32'(cur), 32'(prev));
            end
            if (out_valid && out_ready) begin
                $display("beat data=%h sop=%b eop=%b", cur.data, cur.sop, cur.eop);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", cur);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat", 32'(cur), 32'(exp));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur;
        end
    end

    initial begin
        int  n;
        logic seen;

        // 1: reset values while held and just after release
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_overrun", 32'(overrun), 32'd0);
            check("rst_dropped", 32'(dropped_frames), 32'd0);
            check("rst_out_data", 32'({out_startofpacket, out_endofpacket, out_data}), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // 2: one frame, downstream always ready, latency bound
        out_ready = 1'b1;
        push_frame(16'h0001);
        for (int i = 1; i <= 7; i++)
            send(16'(i));
        send(16'h0008);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("latency", 32'(seen), 32'd1);
        wait_drain("t2_drain");

        // 3: toggling out_ready
        push_frame(16'h0011);
        fork
            send_frame(16'h0011);
            begin
                for (int i = 0; i < 40; i++) begin
                    out_ready = (i % 2 == 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("t3_drain");
        check("t3_dropped", 32'(dropped_frames), 32'd0);

        // 4: stalled downstream, third frame dropped
        out_ready = 1'b0;
        push_frame(16'h0001);
        push_frame(16'h0009);
        for (int i = 1; i <= 24; i++)
            send(16'(i));
        check("t4_dropped", 32'(dropped_frames), 32'd1);
        check("t4_overrun", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        wait_drain("t4_drain");
        check("t4_dropped_after", 32'(dropped_frames), 32'd1);

        pulse_reset();
        check("t5_rst_dropped", 32'(dropped_frames), 32'd0);
        check("t5_rst_overrun", 32'(overrun), 32'd0);

        // 5: frame B completes on the same cycle frame A's EOP transfers
        out_ready = 1'b0;
        push_frame(16'h0021);
        push_frame(16'h0031);
        push_frame(16'h0041);
        send_frame(16'h0021);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_a_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < FRAME_LEN - 1; i++)
            send(16'h0031 + 16'(i));
        out_ready = 1'b1;
        repeat (FRAME_LEN - 1) begin
            @(posedge clk);
            #1;
        end
        send(16'h0038);
        @(posedge clk);
        #1;
        check("t5_gap", 32'(out_valid), 32'd1);
        send_frame(16'h0041);
        wait_drain("t5_drain");
        check("t5_dropped", 32'(dropped_frames), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);

        // 6: reset discards a partial frame
        for (int i = 0; i < 5; i++)
            send(16'h00A1 + 16'(i));
        pulse_reset();
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        push_frame(16'h0100);
        send_frame(16'h0100);
        wait_drain("t6_drain");
        check("t6_dropped", 32'(dropped_frames), 32'd0);

        repeat (20) @(posedge clk);
        #1;
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
